hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Load-use hazard and destination-tracking unit for the 16-bit pipelined core. It sits beside the decode stage and tracks the destination register of every instruction in flight through EX, MEM and WB. Its forwarding-side ports feed the forwarding unit's destination compare. When a decode-stage source depends on a load whose data cannot yet be forwarded, it holds IF/ID and injects a bubble into EX. It also keeps a saturating stall counter for performance debug.

## Interface
- LOAD_LAT, 1: stages after EX before load data is forwardable. Legal values are 1 or 2.
- REG_W, 4: register-address width (16 architectural registers, all ordinary; no hardwired zero).
- CNT_W, 16: stall-counter width.

Ports:
- CLOCK  in  1  single clock, rising edge.
- in_rst_n  in  1  reset, asynchronous, active-low.
- in_valid_id  in  1  decode stage holds a real instruction.
- in_op1_id  in  REG_W  source register 1 of the decode instruction.
- in_op2_id  in  REG_W  source register 2 of the decode instruction.
- in_use_op1, in_use_op2  in  1 each  source is actually read.
- in_dest_id  in  REG_W  destination register of the decode instruction.
- in_wr_en_id  in  1  decode instruction writes a register.
- in_is_load_id  in  1  decode instruction is a load.
- in_flush  in  1  branch redirect; squash decode, EX and MEM.
- out_stall  out  1  hold PC and IF/ID this cycle.
- out_bubble  out  1  EX receives a NOP next edge.
- out_ex_dest, out_mem_dest, out_wb_dest  out  REG_W each  tracked destinations.
- out_ex_wr, out_mem_wr, out_wb_wr  out  1 each  tracked entry valid and writing.
- out_stall_cnt  out  CNT_W  stalls since reset, saturating.

## Operation
- Tracking pipe has three entries, EX, MEM and WB. Each entry holds {valid, wr_en, is_load, dest}. All entries reset to zero.
- A producer stage is *blocking* when all of the following hold:
  - its entry is valid, wr_en and is_load;
  - its dest equals a used source of a valid decode instruction;
  - the stage is EX, or, when LOAD_LAT=2, the stage is EX or MEM.
- Non-load producers never block; the forwarding unit covers them.
- out_stall = in_valid_id & any blocking stage & !in_flush.
- out_bubble = out_stall | in_flush.
- Each rising edge:
  - WB takes MEM.
  - MEM takes EX, or zero if in_flush.
  - EX takes the decode fields if in_valid_id & !out_bubble, otherwise zero.
- The out_*_dest and out_*_wr outputs come straight from the registered entries. out_*_wr = valid & wr_en.
- out_stall_cnt increments on each edge where out_stall=1 and holds at all-ones.
- Simultaneous flush and hazard: flush wins. No stall is raised, and the count does not increment.
- Two sources matching the same or different blocking stages still produce a single stall for that cycle.
- A match against WB, or against MEM when LOAD_LAT=1, is not a stall.
- A decode instruction whose own dest equals its source is not a hazard against itself.

## Timing
- out_stall and out_bubble are combinational from the registered entries and the current decode inputs. They are valid the same cycle, before the edge.
- Load-use with LOAD_LAT=1 gives exactly 1 stall cycle. With LOAD_LAT=2, a load immediately followed by its consumer stalls 2 cycles; a consumer one instruction later stalls 1 cycle.
- Tracked outputs change one edge after decode acceptance (EX), then two edges after (MEM), then three (WB).
- Reset values: all entries, out_*_dest, out_*_wr and out_stall_cnt are 0. out_stall and out_bubble are 0 while in_valid_id=0.
- Asserting in_rst_n low mid-stall clears everything immediately, without waiting for the clock. The first edge after release accepts the decode instruction normally.

## Structure
- hazard_pkg holds:
  - REG_W and CNT_W defaults;
  - the stage-entry typedef {valid, wr_en, is_load, dest};
  - the all-zero ENTRY_NOP constant.
- One sub-module, hazard_stage_reg: a single entry register with async active-low clear, a synchronous clear (flush or bubble) and a load input. It is instantiated three times.
- The match, stall and counter logic stays in the top module.

## Test plan
- Reset released with all inputs idle for 5 cycles → all outputs 0, counter 0.
- Load r2 at decode, then next decode uses op1=r2 (LOAD_LAT=1) → out_stall=1 for 1 cycle, EX bubble, out_ex_dest=2 then out_mem_dest=2, counter=1.
- Same sequence with LOAD_LAT=2 → 2 stall cycles, counter=2. A consumer placed one instruction later → 1 stall cycle.
- ALU write r6 followed by a use of r6 → no stall; out_ex_wr=1 with out_ex_dest=6 on the next cycle.
- Load r1 followed by a use of r1, with in_flush asserted in the stall cycle → out_stall=0, out_bubble=1, EX and MEM cleared, counter unchanged.
- Force 2^CNT_W+3 stall cycles (CNT_W overridden to 4) → counter saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, stage-entry type and load-hit helper for the hazard stall unit
package hazard_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } entry_t;

    localparam entry_t ENTRY_NOP = '0;

    // A tracked entry is a load hazard when it is a valid writing load whose
    // destination equals one of the decode sources that is actually read.
    function automatic logic load_hit(
        input entry_t           e,
        input logic [REG_W-1:0] op1,
        input logic [REG_W-1:0] op2,
        input logic             use1,
        input logic             use2
    );
        return e.valid & e.wr_en & e.is_load &
               ((use1 & (e.dest == op1)) | (use2 & (e.dest == op2)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - decode-side inputs and tracking/stall outputs of the hazard stall unit
interface hazard_stall_unit_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid_id;
    logic [REG_W-1:0] in_op1_id;
    logic [REG_W-1:0] in_op2_id;
    logic             in_use_op1;
    logic             in_use_op2;
    logic [REG_W-1:0] in_dest_id;
    logic             in_wr_en_id;
    logic             in_is_load_id;
    logic             in_flush;

    logic             out_stall;
    logic             out_bubble;
    logic [REG_W-1:0] out_ex_dest;
    logic [REG_W-1:0] out_mem_dest;
    logic [REG_W-1:0] out_wb_dest;
    logic             out_ex_wr;
    logic             out_mem_wr;
    logic             out_wb_wr;
    logic [CNT_W-1:0] out_stall_cnt;

    modport master (
        output in_valid_id, in_op1_id, in_op2_id, in_use_op1, in_use_op2,
               in_dest_id, in_wr_en_id, in_is_load_id, in_flush,
        input  out_stall, out_bubble, out_ex_dest, out_mem_dest, out_wb_dest,
               out_ex_wr, out_mem_wr, out_wb_wr, out_stall_cnt
    );

    modport slave (
        input  in_valid_id, in_op1_id, in_op2_id, in_use_op1, in_use_op2,
               in_dest_id, in_wr_en_id, in_is_load_id, in_flush,
        output out_stall, out_bubble, out_ex_dest, out_mem_dest, out_wb_dest,
               out_ex_wr, out_mem_wr, out_wb_wr, out_stall_cnt
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one tracked pipeline entry with async clear, sync clear and load
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   ld,
    input  entry_t d,
    output entry_t q
);

    // Sync clear dominates load so a squashed slot always becomes a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ENTRY_NOP;
        end else if (clr) begin
            q <= ENTRY_NOP;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall detection and EX/MEM/WB destination tracking
module hazard_stall_unit #(
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = hazard_pkg::REG_W,
    parameter int CNT_W    = hazard_pkg::CNT_W
) (
    input  logic               CLOCK,
    input  logic               in_rst_n,
    hazard_stall_unit_if.slave bus
);

    import hazard_pkg::*;

    entry_t           dec_entry;
    entry_t           ex_q;
    entry_t           mem_q;
    entry_t           wb_q;
    logic [REG_W-1:0] op1;
    logic [REG_W-1:0] op2;
    logic             ex_hit;
    logic             mem_hit;
    logic             stall;
    logic             bubble;
    logic             ex_clr;
    logic [CNT_W-1:0] stall_cnt;

    assign op1 = bus.in_op1_id;
    assign op2 = bus.in_op2_id;

    // Pack the decode fields into the entry EX would capture.
    always_comb begin
        dec_entry         = ENTRY_NOP;
        dec_entry.valid   = 1'b1;
        dec_entry.wr_en   = bus.in_wr_en_id;
        dec_entry.is_load = bus.in_is_load_id;
        dec_entry.dest    = bus.in_dest_id;
    end

    // Loads in EX always block; a load in MEM blocks only when data needs a second stage.
    always_comb begin
        ex_hit  = load_hit(ex_q, op1, op2, bus.in_use_op1, bus.in_use_op2);
        mem_hit = (LOAD_LAT == 2) &&
                  load_hit(mem_q, op1, op2, bus.in_use_op1, bus.in_use_op2);
        stall   = bus.in_valid_id & (ex_hit | mem_hit) & ~bus.in_flush;
        bubble  = stall | bus.in_flush;
        ex_clr  = bubble | ~bus.in_valid_id;
    end

    hazard_stage_reg u_ex (
        .clk   (CLOCK),
        .rst_n (in_rst_n),
        .clr   (ex_clr),
        .ld    (1'b1),
        .d     (dec_entry),
        .q     (ex_q)
    );

    hazard_stage_reg u_mem (
        .clk   (CLOCK),
        .rst_n (in_rst_n),
        .clr   (bus.in_flush),
        .ld    (1'b1),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_stage_reg u_wb (
        .clk   (CLOCK),
        .rst_n (in_rst_n),
        .clr   (1'b0),
        .ld    (1'b1),
        .d     (mem_q),
        .q     (wb_q)
    );

    // Saturating count of stall cycles for performance debug.
    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.out_stall     = stall;
    assign bus.out_bubble    = bubble;
    assign bus.out_ex_dest   = ex_q.dest;
    assign bus.out_mem_dest  = mem_q.dest;
    assign bus.out_wb_dest   = wb_q.dest;
    assign bus.out_ex_wr     = ex_q.valid & ex_q.wr_en;
    assign bus.out_mem_wr    = mem_q.valid & mem_q.wr_en;
    assign bus.out_wb_wr     = wb_q.valid & wb_q.wr_en;
    assign bus.out_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized and directed self-check of hazard_stall_unit against a reference model
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REG_W(4), .CNT_W(16)) b0 ();
    hazard_stall_unit_if #(.REG_W(4), .CNT_W(16)) b1 ();
    hazard_stall_unit_if #(.REG_W(4), .CNT_W(4))  b2 ();

    hazard_stall_unit #(.LOAD_LAT(1), .REG_W(4), .CNT_W(16)) dut0 (.CLOCK(clk), .in_rst_n(rst_n), .bus(b0));
    hazard_stall_unit #(.LOAD_LAT(2), .REG_W(4), .CNT_W(16)) dut1 (.CLOCK(clk), .in_rst_n(rst_n), .bus(b1));
    hazard_stall_unit #(.LOAD_LAT(1), .REG_W(4), .CNT_W(4))  dut2 (.CLOCK(clk), .in_rst_n(rst_n), .bus(b2));

    logic        o_stall [3];
    logic        o_bub   [3];
    logic [3:0]  o_exd   [3];
    logic [3:0]  o_memd  [3];
    logic [3:0]  o_wbd   [3];
    logic        o_exw   [3];
    logic        o_memw  [3];
    logic        o_wbw   [3];
    logic [15:0] o_cnt   [3];

    assign o_stall[0] = b0.out_stall;  assign o_stall[1] = b1.out_stall;  assign o_stall[2] = b2.out_stall;
    assign o_bub[0]   = b0.out_bubble; assign o_bub[1]   = b1.out_bubble; assign o_bub[2]   = b2.out_bubble;
    assign o_exd[0]   = b0.out_ex_dest;  assign o_exd[1]  = b1.out_ex_dest;  assign o_exd[2]  = b2.out_ex_dest;
    assign o_memd[0]  = b0.out_mem_dest; assign o_memd[1] = b1.out_mem_dest; assign o_memd[2] = b2.out_mem_dest;
    assign o_wbd[0]   = b0.out_wb_dest;  assign o_wbd[1]  = b1.out_wb_dest;  assign o_wbd[2]  = b2.out_wb_dest;
    assign o_exw[0]   = b0.out_ex_wr;  assign o_exw[1]  = b1.out_ex_wr;  assign o_exw[2]  = b2.out_ex_wr;
    assign o_memw[0]  = b0.out_mem_wr; assign o_memw[1] = b1.out_mem_wr; assign o_memw[2] = b2.out_mem_wr;
    assign o_wbw[0]   = b0.out_wb_wr;  assign o_wbw[1]  = b1.out_wb_wr;  assign o_wbw[2]  = b2.out_wb_wr;
    assign o_cnt[0]   = b0.out_stall_cnt;
    assign o_cnt[1]   = b1.out_stall_cnt;
    assign o_cnt[2]   = {12'd0, b2.out_stall_cnt};

    // Reference model: each instance keeps the list of instructions in flight,
    // index 0 = one edge after decode, 1 = two edges, 2 = three edges.
    typedef struct packed {
        bit       v;
        bit       w;
        bit       l;
        bit [3:0] d;
    } ent_t;

    ent_t        flight [3][3];
    int unsigned mcnt   [3];
    int          lat    [3] = '{1, 2, 1};
    int unsigned cmax   [3] = '{65535, 65535, 15};

    bit       c_v, c_u1, c_u2, c_w, c_l, c_fl;
    bit [3:0] c_op1, c_op2, c_d;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // A stall happens when some load still younger than its forwarding point
    // produces a register the decode instruction reads.
    function automatic bit exp_stall(input int k);
        bit hit = 0;
        if (!c_v || c_fl) return 0;
        for (int s = 0; s < lat[k]; s++) begin
            if (flight[k][s].v && flight[k][s].w && flight[k][s].l &&
                ((c_u1 && flight[k][s].d == c_op1) || (c_u2 && flight[k][s].d == c_op2)))
                hit = 1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            for (int s = 0; s < 3; s++) flight[k][s] = '0;
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 3; k++) begin
            bit st = exp_stall(k);
            if (st && mcnt[k] < cmax[k]) mcnt[k]++;
            flight[k][2] = flight[k][1];
            flight[k][1] = c_fl ? '0 : flight[k][0];
            flight[k][0] = (c_v && !(st || c_fl)) ? ent_t'{1'b1, c_w, c_l, c_d} : '0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit st = exp_stall(k);
            chk($sformatf("stall%0d", k),  o_stall[k], st);
            chk($sformatf("bubble%0d", k), o_bub[k], st | c_fl);
            chk($sformatf("exd%0d", k),    o_exd[k],  flight[k][0].d);
            chk($sformatf("memd%0d", k),   o_memd[k], flight[k][1].d);
            chk($sformatf("wbd%0d", k),    o_wbd[k],  flight[k][2].d);
            chk($sformatf("exw%0d", k),    o_exw[k],  flight[k][0].v & flight[k][0].w);
            chk($sformatf("memw%0d", k),   o_memw[k], flight[k][1].v & flight[k][1].w);
            chk($sformatf("wbw%0d", k),    o_wbw[k],  flight[k][2].v & flight[k][2].w);
            chk($sformatf("cnt%0d", k),    o_cnt[k],  mcnt[k]);
        end
    endtask

    task automatic drive(input bit v, input bit [3:0] op1, input bit u1, input bit [3:0] op2, input bit u2,
                         input bit [3:0] d, input bit w, input bit l, input bit fl);
        c_v = v; c_op1 = op1; c_u1 = u1; c_op2 = op2; c_u2 = u2; c_d = d; c_w = w; c_l = l; c_fl = fl;
        b0.in_valid_id = v; b0.in_op1_id = op1; b0.in_use_op1 = u1; b0.in_op2_id = op2; b0.in_use_op2 = u2;
        b0.in_dest_id = d; b0.in_wr_en_id = w; b0.in_is_load_id = l; b0.in_flush = fl;
        b1.in_valid_id = v; b1.in_op1_id = op1; b1.in_use_op1 = u1; b1.in_op2_id = op2; b1.in_use_op2 = u2;
        b1.in_dest_id = d; b1.in_wr_en_id = w; b1.in_is_load_id = l; b1.in_flush = fl;
        b2.in_valid_id = v; b2.in_op1_id = op1; b2.in_use_op1 = u1; b2.in_op2_id = op2; b2.in_use_op2 = u2;
        b2.in_dest_id = d; b2.in_wr_en_id = w; b2.in_is_load_id = l; b2.in_flush = fl;
    endtask

    // One decode cycle: drive after the falling edge, check, then advance the model.
    // Returns 1 ns after the falling edge so callers can add directed checks.
    task automatic cyc(input bit v, input bit [3:0] op1, input bit u1, input bit [3:0] op2, input bit u2,
                       input bit [3:0] d, input bit w, input bit l, input bit fl);
        @(negedge clk);
        drive(v, op1, u1, op2, u2, d, w, l, fl);
        #1;
        check_all();
        model_advance();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (5) idle();
        chk("rst_cnt", o_cnt[0], 0);
        chk("rst_stall", o_stall[1], 0);

        // load r2 then consumer of r2, held in decode while stalled
        cyc(1, 0, 0, 0, 0, 2, 1, 1, 0);
        cyc(1, 2, 1, 0, 0, 5, 1, 0, 0);
        chk("lu_stall_l1", o_stall[0], 1);
        chk("lu_stall_l2", o_stall[1], 1);
        cyc(1, 2, 1, 0, 0, 5, 1, 0, 0);
        chk("lu_second_l1", o_stall[0], 0);
        chk("lu_second_l2", o_stall[1], 1);
        chk("lu_memd_l1", o_memd[0], 2);
        chk("lu_exd_bubble", o_exd[0], 0);
        cyc(1, 2, 1, 0, 0, 5, 1, 0, 0);
        chk("lu_third_l2", o_stall[1], 0);
        chk("lu_cnt_l1", o_cnt[0], 1);
        chk("lu_cnt_l2", o_cnt[1], 2);
        repeat (3) idle();

        // consumer one instruction after the load: only LOAD_LAT=2 stalls, once
        cyc(1, 0, 0, 0, 0, 2, 1, 1, 0);
        cyc(1, 9, 1, 0, 0, 9, 1, 0, 0);
        cyc(1, 0, 0, 2, 1, 7, 1, 0, 0);
        chk("gap_stall_l2", o_stall[1], 1);
        chk("gap_stall_l1", o_stall[0], 0);
        cyc(1, 0, 0, 2, 1, 7, 1, 0, 0);
        chk("gap_cnt_l2", o_cnt[1], 3);
        chk("gap_cnt_l1", o_cnt[0], 1);

        // ALU producer never stalls
        cyc(1, 0, 0, 0, 0, 6, 1, 0, 0);
        cyc(1, 6, 1, 6, 1, 3, 1, 0, 0);
        chk("alu_nostall", o_stall[1], 0);
        chk("alu_exd", o_exd[0], 6);
        chk("alu_exw", o_exw[0], 1);

        // flush in the stall cycle wins
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc(1, 1, 1, 0, 0, 4, 1, 0, 1);
        chk("fl_stall", o_stall[0], 0);
        chk("fl_bubble", o_bub[0], 1);
        idle();
        chk("fl_exw", o_exw[0], 0);
        chk("fl_memw", o_memw[0], 0);
        chk("fl_cnt", o_cnt[0], 1);

        // many load-use pairs saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
            cyc(1, 3, 1, 3, 1, 8, 1, 0, 0);
        end
        idle();
        chk("sat_cnt", o_cnt[2], 15);

        // randomized traffic over a small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                4'($urandom_range(0, 3)), 1'($urandom),
                4'($urandom_range(0, 3)), 1'($urandom),
                4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0);
        end

        // asynchronous reset in the middle of a stall
        cyc(1, 0, 0, 0, 0, 5, 1, 1, 0);
        @(negedge clk);
        drive(1, 5, 1, 0, 0, 11, 1, 0, 0);
        #1;
        chk("pre_rst_stall", o_stall[0], 1);
        check_all();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stall", o_stall[0], 0);
        chk("arst_exw", o_exw[1], 0);
        chk("arst_exd", o_exd[1], 0);
        chk("arst_cnt", o_cnt[1], 0);
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        model_advance();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_exd", o_exd[0], 11);
        chk("post_rst_exw", o_exw[1], 1);
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
